// File: rtl/output_row_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// out_sched_pkg
// Shared definitions for the output write-back row scheduler:
//   - default widths for address, COUNTER0, row-group count and enable-control
//   - scheduler state encoding
//   - length of the guard window after a sender accepts a request, during
//     which the sender's busy flag is not yet meaningful
// -----------------------------------------------------------------------------
package out_sched_pkg;

    localparam int AW_DEF = 16;   // write-address width
    localparam int CW_DEF = 8;    // COUNTER0 width
    localparam int RW_DEF = 8;    // row-group count width
    localparam int EW_DEF = 6;    // OUTPUT_EN_CTRL width

    // Cycles after acceptance in which sender busy is ignored.
    localparam int GUARD_CYCLES = 1;
    localparam int GUARD_W      = 2;
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_NEXT      = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_t;

endpackage

// File: rtl/output_row_scheduler_addr_gen.sv
// -----------------------------------------------------------------------------
// output_addr_gen
// Per-group write address and enable-control generator. i_load copies the
// group-0 values in; i_advance steps to the next group (address += stride,
// enable-control += 1, both wrapping silently at their width).
// Ports:
//   CLK, RSTL          clock, asynchronous active-low reset
//   i_load             load i_base / i_ctrl (has priority over i_advance)
//   i_advance          advance to the next row-group
//   i_base, i_stride   group-0 address and per-group increment
//   i_ctrl             group-0 enable-control
//   o_addr, o_ctrl     current group address and enable-control (registered)
// -----------------------------------------------------------------------------
module output_addr_gen
    import out_sched_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int EW = EW_DEF
)(
    input  logic          CLK,
    input  logic          RSTL,
    input  logic          i_load,
    input  logic          i_advance,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_stride,
    input  logic [EW-1:0] i_ctrl,
    output logic [AW-1:0] o_addr,
    output logic [EW-1:0] o_ctrl
);

    logic [AW-1:0] r_addr;
    logic [EW-1:0] r_ctrl;

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            r_addr <= '0;
            r_ctrl <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
            r_ctrl <= i_ctrl;
        end else if (i_advance) begin
            r_addr <= r_addr + i_stride;
            r_ctrl <= r_ctrl + EW'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/output_row_scheduler.sv
// -----------------------------------------------------------------------------
// output_row_scheduler
// Sequences the output write-back of a layer: one start request per row-group
// to either the pooled sender or the plain sender, waiting for each sender run
// to finish before stepping address / enable-control to the next group.
// Ports:
//   CLK, RSTL                    clock, asynchronous active-low reset
//   CFG_START                    start pulse, latches all CFG_* (IDLE only)
//   CFG_POOL/ROWS/COUNT/BASE/STRIDE/CTRL   layer configuration
//   ABORT                        synchronous abort of the running layer
//   MODULE_BUSY                  shared-memory busy; blocks request acceptance
//   POOL_BUSY, SEND_BUSY         busy flags of the pooled / plain sender
//   OUTPUT_SEND_POOL, OUTPUT_SEND  level requests, held until accepted
//   COUNTER0, WADDRX_I, OUTPUT_EN_CTRL_I, ROW_IDX   per-group sender inputs
//   SCHED_BUSY                   layer in progress
//   SCHED_DONE                   one-cycle pulse on normal completion
// All outputs are registered.
// -----------------------------------------------------------------------------
module output_row_scheduler
    import out_sched_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF,
    parameter int RW = RW_DEF,
    parameter int EW = EW_DEF
)(
    input  logic          CLK,
    input  logic          RSTL,
    input  logic          CFG_START,
    input  logic          CFG_POOL,
    input  logic [RW-1:0] CFG_ROWS,
    input  logic [CW-1:0] CFG_COUNT,
    input  logic [AW-1:0] CFG_BASE,
    input  logic [AW-1:0] CFG_STRIDE,
    input  logic [EW-1:0] CFG_CTRL,
    input  logic          ABORT,
    input  logic          MODULE_BUSY,
    input  logic          POOL_BUSY,
    input  logic          SEND_BUSY,
    output logic          OUTPUT_SEND_POOL,
    output logic          OUTPUT_SEND,
    output logic [CW-1:0] COUNTER0,
    output logic [AW-1:0] WADDRX_I,
    output logic [EW-1:0] OUTPUT_EN_CTRL_I,
    output logic [RW-1:0] ROW_IDX,
    output logic          SCHED_BUSY,
    output logic          SCHED_DONE
);

    sched_state_t        r_state, w_state_next;
    logic                r_pool;
    logic [RW-1:0]       r_rows;
    logic [CW-1:0]       r_count;
    logic [AW-1:0]       r_stride;
    logic [RW-1:0]       r_row_idx;
    logic [GUARD_W-1:0]  r_guard, w_guard_next;
    logic                r_req_pool, r_req_send;
    logic                r_busy, r_done;

    logic                w_req, w_accept, w_sel_busy, w_start_acc;
    logic                w_req_next, w_pool_sel, w_load, w_advance;
    logic [RW-1:0]       w_row_inc;

    assign w_req      = r_req_pool | r_req_send;
    // Same acceptance rule the senders apply, so both sides agree on the cycle.
    assign w_accept   = w_req & ~MODULE_BUSY;
    assign w_sel_busy = r_pool ? POOL_BUSY : SEND_BUSY;
    // SCHED_BUSY stays high for the cycle SCHED_DONE pulses, so a start in that
    // cycle is ignored as well.
    assign w_start_acc = (r_state == ST_IDLE) && CFG_START && !r_busy;
    assign w_row_inc  = r_row_idx + RW'(1);
    assign w_pool_sel = w_load ? CFG_POOL : r_pool;

    always_comb begin
        w_state_next = r_state;
        w_guard_next = r_guard;
        w_req_next   = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_load = 1'b1;
                    if (CFG_ROWS == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ISSUE;
                        w_req_next   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_accept) begin
                    // The sender has started even if ABORT arrives now, so its
                    // run must be drained before going idle.
                    w_guard_next = GUARD_LOAD;
                    w_state_next = ABORT ? ST_DRAIN : ST_WAIT_DONE;
                end else if (ABORT) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_req_next = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (r_guard != '0)
                    w_guard_next = r_guard - GUARD_W'(1);
                if (ABORT)
                    w_state_next = ST_DRAIN;
                else if (r_guard == '0 && !w_sel_busy)
                    w_state_next = ST_NEXT;
            end
            ST_DRAIN: begin
                if (r_guard != '0)
                    w_guard_next = r_guard - GUARD_W'(1);
                else if (!w_sel_busy)
                    w_state_next = ST_IDLE;
            end
            ST_NEXT: begin
                if (ABORT) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_advance = 1'b1;
                    if (w_row_inc == r_rows) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ISSUE;
                        w_req_next   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            r_state    <= ST_IDLE;
            r_pool     <= 1'b0;
            r_rows     <= '0;
            r_count    <= '0;
            r_stride   <= '0;
            r_row_idx  <= '0;
            r_guard    <= '0;
            r_req_pool <= 1'b0;
            r_req_send <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_guard    <= w_guard_next;
            r_req_pool <= w_req_next & w_pool_sel;
            r_req_send <= w_req_next & ~w_pool_sel;
            r_busy     <= (w_state_next != ST_IDLE) || (r_state == ST_DONE);
            r_done     <= (r_state == ST_DONE);
            if (w_load) begin
                r_pool    <= CFG_POOL;
                r_rows    <= CFG_ROWS;
                r_count   <= CFG_COUNT;
                r_stride  <= CFG_STRIDE;
                r_row_idx <= '0;
            end else if (w_advance) begin
                r_row_idx <= w_row_inc;
            end
        end
    end

    output_addr_gen #(
        .AW (AW),
        .EW (EW)
    ) u_addr_gen (
        .CLK       (CLK),
        .RSTL      (RSTL),
        .i_load    (w_load),
        .i_advance (w_advance),
        .i_base    (CFG_BASE),
        .i_stride  (r_stride),
        .i_ctrl    (CFG_CTRL),
        .o_addr    (WADDRX_I),
        .o_ctrl    (OUTPUT_EN_CTRL_I)
    );

    assign OUTPUT_SEND_POOL = r_req_pool;
    assign OUTPUT_SEND      = r_req_send;
    assign COUNTER0         = r_count;
    assign ROW_IDX          = r_row_idx;
    assign SCHED_BUSY       = r_busy;
    assign SCHED_DONE       = r_done;

endmodule

// File: tb/tb_output_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_output_row_scheduler
// Drives directed layer scenarios followed by randomized traffic against
// output_row_scheduler. Two sender models respond to accepted requests with a
// busy window that starts one cycle after acceptance. A layer-level model
// predicts every output each cycle; directed scenarios also pin literal values.
// -----------------------------------------------------------------------------
module tb_output_row_scheduler;

    logic        CLK;
    logic        RSTL;
    logic        CFG_START;
    logic        CFG_POOL;
    logic [7:0]  CFG_ROWS;
    logic [7:0]  CFG_COUNT;
    logic [15:0] CFG_BASE;
    logic [15:0] CFG_STRIDE;
    logic [5:0]  CFG_CTRL;
    logic        ABORT;
    logic        MODULE_BUSY;
    logic        POOL_BUSY;
    logic        SEND_BUSY;
    logic        OUTPUT_SEND_POOL;
    logic        OUTPUT_SEND;
    logic [7:0]  COUNTER0;
    logic [15:0] WADDRX_I;
    logic [5:0]  OUTPUT_EN_CTRL_I;
    logic [7:0]  ROW_IDX;
    logic        SCHED_BUSY;
    logic        SCHED_DONE;

    output_row_scheduler dut (
        .CLK              (CLK),
        .RSTL             (RSTL),
        .CFG_START        (CFG_START),
        .CFG_POOL         (CFG_POOL),
        .CFG_ROWS         (CFG_ROWS),
        .CFG_COUNT        (CFG_COUNT),
        .CFG_BASE         (CFG_BASE),
        .CFG_STRIDE       (CFG_STRIDE),
        .CFG_CTRL         (CFG_CTRL),
        .ABORT            (ABORT),
        .MODULE_BUSY      (MODULE_BUSY),
        .POOL_BUSY        (POOL_BUSY),
        .SEND_BUSY        (SEND_BUSY),
        .OUTPUT_SEND_POOL (OUTPUT_SEND_POOL),
        .OUTPUT_SEND      (OUTPUT_SEND),
        .COUNTER0         (COUNTER0),
        .WADDRX_I         (WADDRX_I),
        .OUTPUT_EN_CTRL_I (OUTPUT_EN_CTRL_I),
        .ROW_IDX          (ROW_IDX),
        .SCHED_BUSY       (SCHED_BUSY),
        .SCHED_DONE       (SCHED_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- counters -------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    // ---------------- sender models --------------------------------------
    int p_left = 0, s_left = 0;
    bit p_pend = 0, s_pend = 0;
    int p_len  = 1, s_len  = 1;
    int busy_len  = 4;
    bit busy_rand = 0;

    // ---------------- layer model ----------------------------------------
    localparam int PH_IDLE  = 0;   // waiting for a start
    localparam int PH_REQ   = 1;   // request outstanding
    localparam int PH_RUN   = 2;   // sender running for current group
    localparam int PH_STEP  = 3;   // moving on to the next group
    localparam int PH_FLUSH = 4;   // aborted, letting the sender finish
    localparam int PH_FIN   = 5;   // layer finished
    int          m_ph, m_g, m_since;
    bit          m_pool, m_tail;
    logic [7:0]  m_rows, m_count;
    logic [15:0] m_base, m_stride;
    logic [5:0]  m_ctrl0;

    // ---------------- monitor --------------------------------------------
    int n_pool_req = 0, n_send_req = 0, n_send_cyc = 0, n_done = 0, n_busy_cyc = 0;
    bit prev_p = 0, prev_s = 0;
    int q_addr[$];
    int q_ctrl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int q_at(input int which, input int i);
        if (which == 0) return (i < q_addr.size()) ? q_addr[i] : -1;
        return (i < q_ctrl.size()) ? q_ctrl[i] : -1;
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_g = 0; m_since = 0; m_pool = 0; m_tail = 0;
        m_rows = '0; m_count = '0; m_base = '0; m_stride = '0; m_ctrl0 = '0;
    endtask

    // One clock edge of the layer-level behaviour.
    task automatic model_step();
        bit busy_now, fin_now, sel_busy;
        if (!RSTL) begin
            model_reset();
            return;
        end
        busy_now = (m_ph != PH_IDLE) || m_tail;
        fin_now  = (m_ph == PH_FIN);
        sel_busy = m_pool ? POOL_BUSY : SEND_BUSY;
        case (m_ph)
            PH_IDLE: if (CFG_START && !busy_now) begin
                m_pool = CFG_POOL; m_rows = CFG_ROWS; m_count = CFG_COUNT;
                m_base = CFG_BASE; m_stride = CFG_STRIDE; m_ctrl0 = CFG_CTRL;
                m_g = 0;
                m_ph = (CFG_ROWS == 0) ? PH_FIN : PH_REQ;
            end
            PH_REQ: begin
                if (!MODULE_BUSY) begin
                    m_since = 0;
                    m_ph = ABORT ? PH_FLUSH : PH_RUN;
                end else if (ABORT) begin
                    m_ph = PH_IDLE;
                end
            end
            PH_RUN: begin
                // busy is meaningful from the second cycle after acceptance
                if (ABORT) m_ph = PH_FLUSH;
                else if (m_since >= 1 && !sel_busy) m_ph = PH_STEP;
                m_since++;
            end
            PH_FLUSH: begin
                if (m_since >= 1 && !sel_busy) m_ph = PH_IDLE;
                m_since++;
            end
            PH_STEP: begin
                if (ABORT) m_ph = PH_IDLE;
                else begin
                    m_g++;
                    m_ph = (m_g == int'(m_rows)) ? PH_FIN : PH_REQ;
                end
            end
            default: m_ph = PH_IDLE;   // PH_FIN
        endcase
        m_tail = fin_now;
    endtask

    task automatic sender_step(input bit acc_p, input bit acc_s);
        if (!RSTL) begin
            p_left = 0; s_left = 0; p_pend = 0; s_pend = 0;
        end else begin
            if (p_pend) begin p_pend = 0; p_left = p_len; end
            else if (p_left > 0) p_left--;
            if (s_pend) begin s_pend = 0; s_left = s_len; end
            else if (s_left > 0) s_left--;
            if (acc_p) begin p_pend = 1; p_len = busy_rand ? int'($urandom_range(1, 6)) : busy_len; end
            if (acc_s) begin s_pend = 1; s_len = busy_rand ? int'($urandom_range(1, 6)) : busy_len; end
        end
        POOL_BUSY = (p_left > 0);
        SEND_BUSY = (s_left > 0);
    endtask

    task automatic compare_all();
        bit          e_req;
        logic [15:0] e_addr;
        logic [5:0]  e_ctrl;
        e_req  = (m_ph == PH_REQ);
        e_addr = 16'(int'(m_base) + m_g * int'(m_stride));
        e_ctrl = 6'(int'(m_ctrl0) + m_g);
        chk("OUTPUT_SEND_POOL", OUTPUT_SEND_POOL, e_req && m_pool);
        chk("OUTPUT_SEND",      OUTPUT_SEND,      e_req && !m_pool);
        chk("COUNTER0",         COUNTER0,         m_count);
        chk("WADDRX_I",         WADDRX_I,         e_addr);
        chk("OUTPUT_EN_CTRL_I", OUTPUT_EN_CTRL_I, e_ctrl);
        chk("ROW_IDX",          ROW_IDX,          8'(m_g));
        chk("SCHED_BUSY",       SCHED_BUSY,       (m_ph != PH_IDLE) || m_tail);
        chk("SCHED_DONE",       SCHED_DONE,       m_tail);
    endtask

    task automatic monitor();
        if (OUTPUT_SEND_POOL && !prev_p) begin
            n_pool_req++;
            q_addr.push_back(int'(WADDRX_I)); q_ctrl.push_back(int'(OUTPUT_EN_CTRL_I));
            $display("[%0t] pool request  addr=0x%04h ctrl=%0d idx=%0d cnt=%0d",
                     $time, WADDRX_I, OUTPUT_EN_CTRL_I, ROW_IDX, COUNTER0);
        end
        if (OUTPUT_SEND && !prev_s) begin
            n_send_req++;
            q_addr.push_back(int'(WADDRX_I)); q_ctrl.push_back(int'(OUTPUT_EN_CTRL_I));
            $display("[%0t] plain request addr=0x%04h ctrl=%0d idx=%0d cnt=%0d",
                     $time, WADDRX_I, OUTPUT_EN_CTRL_I, ROW_IDX, COUNTER0);
        end
        if (OUTPUT_SEND) n_send_cyc++;
        if (SCHED_BUSY)  n_busy_cyc++;
        if (SCHED_DONE) begin
            n_done++;
            $display("[%0t] layer done rows=%0d", $time, ROW_IDX);
        end
        prev_p = OUTPUT_SEND_POOL;
        prev_s = OUTPUT_SEND;
    endtask

    // One clock cycle: model and senders advance on the edge, outputs are
    // checked on the falling edge.
    task automatic tick();
        bit acc_p, acc_s;
        acc_p = RSTL && OUTPUT_SEND_POOL && !MODULE_BUSY;
        acc_s = RSTL && OUTPUT_SEND && !MODULE_BUSY;
        @(posedge CLK);
        model_step();
        #1;
        sender_step(acc_p, acc_s);
        @(negedge CLK);
        compare_all();
        monitor();
    endtask

    task automatic start_layer(input bit pool, input int rows, input int count,
                               input int base, input int stride, input int ctrl);
        CFG_POOL = pool; CFG_ROWS = 8'(rows); CFG_COUNT = 8'(count);
        CFG_BASE = 16'(base); CFG_STRIDE = 16'(stride); CFG_CTRL = 6'(ctrl);
        CFG_START = 1'b1;
        tick();
        CFG_START = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (SCHED_BUSY && k < limit) begin
            tick();
            k++;
        end
        chk("wait_idle_timeout", SCHED_BUSY, 0);
    endtask

    int q0, r0, s0, c0, d0, b0, k;
    bit reached;

    initial begin
        RSTL = 1'b0; CFG_START = 0; CFG_POOL = 0; CFG_ROWS = 0; CFG_COUNT = 0;
        CFG_BASE = 0; CFG_STRIDE = 0; CFG_CTRL = 0; ABORT = 0; MODULE_BUSY = 0;
        POOL_BUSY = 0; SEND_BUSY = 0;
        model_reset();
        repeat (3) tick();
        chk("reset_busy",  SCHED_BUSY, 0);
        chk("reset_reqs",  {OUTPUT_SEND_POOL, OUTPUT_SEND}, 0);
        chk("reset_addr",  WADDRX_I, 0);
        RSTL = 1'b1;
        repeat (2) tick();

        // 1: pooled, three groups, long sender runs
        busy_len = 20;
        q0 = q_addr.size(); r0 = n_pool_req; s0 = n_send_req; d0 = n_done;
        start_layer(1, 3, 2, 'h0100, 'h0004, 0);
        wait_idle(300);
        chk("t1_pool_reqs", n_pool_req - r0, 3);
        chk("t1_send_reqs", n_send_req - s0, 0);
        chk("t1_done",      n_done - d0, 1);
        chk("t1_addr0", q_at(0, q0),     'h0100);
        chk("t1_addr1", q_at(0, q0 + 1), 'h0104);
        chk("t1_addr2", q_at(0, q0 + 2), 'h0108);
        chk("t1_ctrl1", q_at(1, q0 + 1), 1);
        chk("t1_ctrl2", q_at(1, q0 + 2), 2);
        repeat (2) tick();

        // 2: plain, MODULE_BUSY blocks acceptance for 5 request cycles
        busy_len = 3;
        c0 = n_send_cyc; s0 = n_send_req; d0 = n_done;
        MODULE_BUSY = 1'b1;
        start_layer(0, 1, 5, 'h0040, 'h0010, 7);
        repeat (5) tick();
        MODULE_BUSY = 1'b0;
        wait_idle(100);
        chk("t2_send_hold", n_send_cyc - c0, 6);
        chk("t2_send_reqs", n_send_req - s0, 1);
        chk("t2_done",      n_done - d0, 1);
        repeat (2) tick();

        // 3: zero rows
        b0 = n_busy_cyc; d0 = n_done; r0 = n_pool_req + n_send_req;
        start_layer(1, 0, 9, 'h1234, 'h0001, 3);
        wait_idle(20);
        chk("t3_busy_cycles", n_busy_cyc - b0, 2);
        chk("t3_done",        n_done - d0, 1);
        chk("t3_no_request",  n_pool_req + n_send_req - r0, 0);
        repeat (2) tick();

        // 4: address and enable-control wrap
        q0 = q_addr.size();
        start_layer(0, 2, 1, 'hFFFC, 'h0008, 63);
        wait_idle(100);
        chk("t4_addr0", q_at(0, q0),     'hFFFC);
        chk("t4_addr1", q_at(0, q0 + 1), 'h0004);
        chk("t4_ctrl0", q_at(1, q0),     63);
        chk("t4_ctrl1", q_at(1, q0 + 1), 0);
        repeat (2) tick();

        // 5: abort while the pooled sender still has 10 busy cycles to go
        busy_len = 20; d0 = n_done;
        start_layer(1, 2, 4, 'h0200, 'h0020, 10);
        reached = 0;
        for (k = 0; k < 100 && !reached; k++) begin
            if (POOL_BUSY && p_left == 10) reached = 1;
            else tick();
        end
        chk("t5_reached_busy", reached, 1);
        b0 = n_busy_cyc;
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        wait_idle(50);
        chk("t5_busy_after_abort", n_busy_cyc - b0, 10);
        chk("t5_no_done",          n_done - d0, 0);
        busy_len = 2; d0 = n_done; s0 = n_send_req;
        start_layer(0, 1, 6, 'h0300, 'h0001, 1);
        wait_idle(50);
        chk("t5_restart_done", n_done - d0, 1);
        chk("t5_restart_req",  n_send_req - s0, 1);
        repeat (2) tick();

        // 6: start ignored while busy, then reset in the middle of ISSUE
        MODULE_BUSY = 1'b1;
        start_layer(1, 2, 'h33, 'h2000, 'h0010, 5);
        repeat (2) tick();
        CFG_COUNT = 8'h77; CFG_BASE = 16'h5555; CFG_START = 1'b1;
        tick();
        CFG_START = 1'b0;
        tick();
        chk("t6_in_issue",   OUTPUT_SEND_POOL, 1);
        chk("t6_count_kept", COUNTER0, 'h33);
        chk("t6_addr_kept",  WADDRX_I, 'h2000);
        #2;
        RSTL = 1'b0;
        model_reset();
        sender_step(0, 0);
        #1;
        chk("t6_rst_reqs", {OUTPUT_SEND_POOL, OUTPUT_SEND}, 0);
        chk("t6_rst_busy", {SCHED_BUSY, SCHED_DONE}, 0);
        chk("t6_rst_data", {COUNTER0, WADDRX_I, OUTPUT_EN_CTRL_I, ROW_IDX}, 0);
        repeat (2) tick();
        RSTL = 1'b1; MODULE_BUSY = 1'b0;
        repeat (2) tick();

        // Randomized traffic checked cycle by cycle against the model
        busy_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            CFG_START   = ($urandom_range(0, 9) == 0);
            CFG_POOL    = 1'($urandom_range(0, 1));
            CFG_ROWS    = 8'($urandom_range(0, 4));
            CFG_COUNT   = 8'($urandom);
            CFG_BASE    = 16'($urandom);
            CFG_STRIDE  = 16'($urandom);
            CFG_CTRL    = 6'($urandom);
            ABORT       = ($urandom_range(0, 49) == 0);
            MODULE_BUSY = ($urandom_range(0, 3) == 0);
            tick();
        end
        CFG_START = 0; ABORT = 0; MODULE_BUSY = 0;
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
